// File: rtl/alu_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// alu_muldiv_pkg
//   Shared ALU control codes (5-bit *_CONTROL encoding) for the execute stage,
//   including the multiply/divide codes, plus small decode helpers.
// -----------------------------------------------------------------------------
package alu_muldiv_pkg;

  localparam logic [4:0] AND_CONTROL   = 5'b00000;
  localparam logic [4:0] OR_CONTROL    = 5'b00001;
  localparam logic [4:0] XOR_CONTROL   = 5'b00010;
  localparam logic [4:0] NOR_CONTROL   = 5'b00011;
  localparam logic [4:0] ADD_CONTROL   = 5'b00100;
  localparam logic [4:0] SUB_CONTROL   = 5'b00101;
  localparam logic [4:0] SLT_CONTROL   = 5'b00110;
  localparam logic [4:0] SLTU_CONTROL  = 5'b00111;
  localparam logic [4:0] SLL_CONTROL   = 5'b01000;
  localparam logic [4:0] SRL_CONTROL   = 5'b01001;
  localparam logic [4:0] SRA_CONTROL   = 5'b01010;
  localparam logic [4:0] SLLV_CONTROL  = 5'b01011;
  localparam logic [4:0] SRLV_CONTROL  = 5'b01100;
  localparam logic [4:0] SRAV_CONTROL  = 5'b01101;
  // Multi-cycle engine codes, kept clear of the single-cycle codes above.
  localparam logic [4:0] MULT_CONTROL  = 5'b10000;
  localparam logic [4:0] MULTU_CONTROL = 5'b10001;
  localparam logic [4:0] DIV_CONTROL   = 5'b10010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b10011;

  // True for any op handled by the multiply/divide engine.
  function automatic logic is_muldiv(input logic [4:0] op);
    logic r;
    case (op)
      MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL: r = 1'b1;
      default:                                               r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the two divide ops.
  function automatic logic is_div(input logic [4:0] op);
    logic r;
    case (op)
      DIV_CONTROL, DIVU_CONTROL: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv_div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
//   Unsigned restoring radix-2 divider: one quotient bit per cycle, exactly
//   WIDTH iteration cycles after the start edge. A zero divisor leaves the
//   registers untouched while the counter still runs, so completion timing is
//   identical to a normal divide.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   i_abort      drop any divide in progress (highest priority after reset)
//   i_start      load operands and begin iterating
//   i_dividend   unsigned dividend magnitude
//   i_divisor    unsigned divisor magnitude
//   o_done       high for the cycle after the last iteration
//   o_quotient   quotient register
//   o_remainder  partial/final remainder register
// -----------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_abort,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_last;
  logic             w_div_zero;

  // Shift the next dividend bit into the remainder and trial-subtract.
  // The remainder stays below the divisor, so WIDTH+1 bits cannot overflow.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_last     = r_busy && (r_cnt == CNT_LAST);
  assign w_div_zero = (r_div == {WIDTH{1'b0}});

  // Iteration register: load on start, one restoring step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
      r_rem  <= {WIDTH{1'b0}};
      r_quo  <= {WIDTH{1'b0}};
      r_div  <= {WIDTH{1'b0}};
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= {CNT_W{1'b0}};
      r_rem  <= {WIDTH{1'b0}};
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
        if (!w_div_zero) begin
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_done      = w_last;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//   Execute-stage ALU: zero-latency arithmetic/logic/shift ops with signed
//   overflow for ADD/SUB, plus a multi-cycle multiply/divide engine that
//   writes HI/LO and handshakes with the pipeline via busy/done.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   op         5-bit *_CONTROL code
//   num1/num2  rs/rt operands
//   sa         immediate shift amount
//   start      issue strobe for MULT/MULTU/DIV/DIVU
//   flush      abort in-flight mul/div (also blocks a same-cycle start)
//   result     combinational result of single-cycle ops
//   overflow   signed overflow of ADD/SUB, 0 otherwise
//   busy       registered, engine occupied
//   done       registered one-cycle pulse on HI/LO update
//   hi/lo      HI/LO result registers
// -----------------------------------------------------------------------------
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int SHAMT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic [SHAMT_W-1:0] sa,
  input  logic               start,
  input  logic               flush,
  output logic [WIDTH-1:0]   result,
  output logic               overflow,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     w_add_ext;
  logic [WIDTH:0]     w_sub_ext;
  logic [SHAMT_W-1:0] w_vshamt;

  // Sign-extended by one bit: overflow shows up as the top two bits differing.
  assign w_add_ext = {num1[WIDTH-1], num1} + {num2[WIDTH-1], num2};
  assign w_sub_ext = {num1[WIDTH-1], num1} - {num2[WIDTH-1], num2};
  assign w_vshamt  = num1[SHAMT_W-1:0];

  // Single-cycle op select; unknown and engine ops drive zero.
  always_comb begin
    result   = {WIDTH{1'b0}};
    overflow = 1'b0;
    case (op)
      ADD_CONTROL: begin
        result   = w_add_ext[WIDTH-1:0];
        overflow = w_add_ext[WIDTH] ^ w_add_ext[WIDTH-1];
      end
      SUB_CONTROL: begin
        result   = w_sub_ext[WIDTH-1:0];
        overflow = w_sub_ext[WIDTH] ^ w_sub_ext[WIDTH-1];
      end
      SLT_CONTROL:  result = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
      SLTU_CONTROL: result = {{(WIDTH-1){1'b0}}, (num1 < num2)};
      AND_CONTROL:  result = num1 & num2;
      OR_CONTROL:   result = num1 | num2;
      XOR_CONTROL:  result = num1 ^ num2;
      NOR_CONTROL:  result = ~(num1 | num2);
      SLL_CONTROL:  result = num2 << sa;
      SRL_CONTROL:  result = num2 >> sa;
      SRA_CONTROL:  result = $signed(num2) >>> sa;
      SLLV_CONTROL: result = num2 << w_vshamt;
      SRLV_CONTROL: result = num2 >> w_vshamt;
      SRAV_CONTROL: result = $signed(num2) >>> w_vshamt;
      default: begin
        result   = {WIDTH{1'b0}};
        overflow = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide engine
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_nxt;
  logic               w_wb_mul;
  logic               w_wb_div;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_issue;
  logic               w_issue_div;
  logic               w_in_signed;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_hi_div;
  logic [WIDTH-1:0]   w_lo_div;

  // Flush always wins over a same-cycle start.
  assign w_issue     = (r_state == ST_IDLE) && start && !flush && is_muldiv(op);
  assign w_issue_div = w_issue && is_div(op);
  assign w_in_signed = (op == MULT_CONTROL) || (op == DIV_CONTROL);

  // Extending to 2*WIDTH makes one unsigned multiply correct for both
  // signednesses modulo 2^(2*WIDTH).
  assign w_mul_a = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_mul_b = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // The divider works on magnitudes taken straight from the issuing operands.
  assign w_dvd_mag = (w_in_signed && num1[WIDTH-1]) ? -num1 : num1;
  assign w_dvs_mag = (w_in_signed && num2[WIDTH-1]) ? -num2 : num2;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .i_abort     (flush),
    .i_start     (w_issue_div),
    .i_dividend  (w_dvd_mag),
    .i_divisor   (w_dvs_mag),
    .o_done      (w_div_done),
    .o_quotient  (w_quo_mag),
    .o_remainder (w_rem_mag)
  );

  // Sign fix-up and divide-by-zero substitution for the HI/LO writeback.
  always_comb begin
    w_hi_div = w_rem_mag;
    w_lo_div = w_quo_mag;
    if (r_b == {WIDTH{1'b0}}) begin
      w_hi_div = r_a;
      w_lo_div = {WIDTH{1'b1}};
    end else begin
      w_hi_div = (r_signed && r_a[WIDTH-1]) ? -w_rem_mag : w_rem_mag;
      w_lo_div = (r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_quo_mag : w_quo_mag;
    end
  end

  // Engine next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_wb_mul    = 1'b0;
    w_wb_div    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = is_div(op) ? ST_DIV : ST_MUL;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_MUL: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt == MUL_LAST) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_wb_mul    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 3'd1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (w_div_done) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_wb_div    = 1'b1;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Engine state, operand latch, product pipeline register and HI/LO writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= 3'd0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_signed <= 1'b0;
      r_prod   <= {(2*WIDTH){1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prod  <= w_prod;
      if (w_issue) begin
        r_a      <= num1;
        r_b      <= num2;
        r_signed <= w_in_signed;
      end
      if (w_wb_mul) begin
        r_hi <= r_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_prod[WIDTH-1:0];
      end else if (w_wb_div) begin
        r_hi <= w_hi_div;
        r_lo <= w_lo_div;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    op;
  logic [W-1:0]  num1, num2;
  logic [4:0]    sa;
  logic          start, flush;
  logic [W-1:0]  result;
  logic          overflow, busy, done;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_hi, m_lo;

  alu_muldiv #(.WIDTH(W), .MUL_STAGES(MS), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .op(op), .num1(num1), .num2(num2), .sa(sa),
    .start(start), .flush(flush), .result(result), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference for single-cycle ops, from plain integer arithmetic.
  task automatic ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, output logic [31:0] r, output logic v);
    longint wide;
    int     t;
    r = 32'd0;
    v = 1'b0;
    case (o)
      ADD_CONTROL: begin
        wide = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        v = (wide > longint'(32'sh7FFFFFFF)) || (wide < longint'(32'sh80000000));
      end
      SUB_CONTROL: begin
        wide = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        v = (wide > longint'(32'sh7FFFFFFF)) || (wide < longint'(32'sh80000000));
      end
      SLT_CONTROL:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU_CONTROL: r = (a < b) ? 32'd1 : 32'd0;
      AND_CONTROL:  r = a & b;
      OR_CONTROL:   r = a | b;
      XOR_CONTROL:  r = a ^ b;
      NOR_CONTROL:  r = ~(a | b);
      SLL_CONTROL:  r = b << s;
      SRL_CONTROL:  r = b >> s;
      SRA_CONTROL:  begin t = $signed(b); t = t >>> s; r = t; end
      SLLV_CONTROL: r = b << a[4:0];
      SRLV_CONTROL: r = b >> a[4:0];
      SRAV_CONTROL: begin t = $signed(b); t = t >>> a[4:0]; r = t; end
      default: begin r = 32'd0; v = 1'b0; end
    endcase
  endtask

  // Reference for the engine: returns {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa_l, sb_l, q, r;
    longint unsigned p;
    logic [63:0]     res;
    res = 64'd0;
    case (o)
      MULT_CONTROL: begin
        q = longint'($signed(a)) * longint'($signed(b));
        res = q;
      end
      MULTU_CONTROL: begin
        p = {32'd0, a} * {32'd0, b};
        res = p;
      end
      DIV_CONTROL: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sa_l = longint'($signed(a));
          sb_l = longint'($signed(b));
          q = sa_l / sb_l;
          r = sa_l % sb_l;
          res = {r[31:0], q[31:0]};
        end
      end
      DIVU_CONTROL: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic comb_check(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] s, input string tag);
    logic [31:0] er;
    logic        ev;
    op = o; num1 = a; num2 = b; sa = s;
    #1;
    ref_alu(o, a, b, s, er, ev);
    check({tag, "_res"}, {32'd0, result}, {32'd0, er});
    check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, ev});
  endtask

  // Issue one engine op and wait for done; returns in the done cycle.
  // With poke set, a second start is driven while the first is in flight.
  task automatic run_md(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input string tag);
    int          lat;
    int          exp_lat;
    logic [63:0] e;
    e = ref_md(o, a, b);
    exp_lat = is_div(o) ? W + 1 : MS + 1;
    op = o; num1 = a; num2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    if (poke) begin
      op = DIVU_CONTROL; num1 = 32'd1; num2 = 32'd1; start = 1'b1;
      tick();
      lat++;
      start = 1'b0;
    end
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  initial begin
    logic [4:0] comb_ops [15];
    logic [4:0] md_ops [4];
    logic [4:0] o;
    logic [31:0] a, b;
    int n_done;

    comb_ops = '{ADD_CONTROL, SUB_CONTROL, SLT_CONTROL, SLTU_CONTROL, AND_CONTROL,
                 OR_CONTROL, XOR_CONTROL, NOR_CONTROL, SLL_CONTROL, SRL_CONTROL,
                 SRA_CONTROL, SLLV_CONTROL, SRLV_CONTROL, SRAV_CONTROL, 5'b11111};
    md_ops = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL};

    rst = 1'b1; op = 5'd0; num1 = 32'd0; num2 = 32'd0; sa = 5'd0;
    start = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);

    // Directed single-cycle cases
    comb_check(ADD_CONTROL, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, "add_ovf");
    check("add_ovf_lit", {32'd0, result}, 64'h8000_0000);
    comb_check(SUB_CONTROL, 32'h8000_0000, 32'h0000_0001, 5'd0, "sub_ovf");
    check("sub_ovf_lit", {32'd0, result}, 64'h7FFF_FFFF);
    comb_check(SRAV_CONTROL, 32'h0000_0024, 32'h8000_0010, 5'd0, "srav");
    check("srav_lit", {32'd0, result}, 64'hF800_0001);
    comb_check(SLTU_CONTROL, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, "sltu");
    comb_check(SLT_CONTROL, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, "slt");
    comb_check(5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, "unknown");
    comb_check(ADD_CONTROL, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, "add_noovf");

    // Random single-cycle ops
    for (int i = 0; i < 60; i++) begin
      o = comb_ops[$urandom_range(0, 14)];
      comb_check(o, $urandom, $urandom, 5'($urandom_range(0, 31)), "rnd_alu");
    end
    op = 5'd0;
    tick();

    // Directed engine cases
    run_md(MULT_CONTROL, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "mult_m2x3");
    check("mult_lit_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_lit_lo", {32'd0, lo}, 64'hFFFF_FFFA);
    tick();
    check("done_pulse", {63'd0, done}, 64'd0);
    run_md(DIV_CONTROL, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_m7_2");
    check("div_lit_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    tick();
    run_md(DIVU_CONTROL, 32'h0000_0007, 32'h0000_0000, 1'b0, "divu_by0");
    check("divu0_lit_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("divu0_lit_hi", {32'd0, hi}, 64'h0000_0007);
    // Back-to-back: issue from the done cycle
    run_md(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "b2b_div_min");
    run_md(MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "b2b_multu");
    tick();
    // Start while busy is ignored
    run_md(MULT_CONTROL, 32'h0001_2345, 32'hFFFF_0003, 1'b1, "mult_poke");
    tick();
    run_md(DIV_CONTROL, 32'h0000_0064, 32'hFFFF_FFF9, 1'b1, "div_poke");
    tick();

    // Random engine ops
    for (int i = 0; i < 10; i++) begin
      o = md_ops[$urandom_range(0, 3)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      run_md(o, a, b, 1'b0, "rnd_md");
      tick();
    end

    // Flush at iteration 10 of a DIVU
    op = DIVU_CONTROL; num1 = 32'hDEAD_BEEF; num2 = 32'h0000_0013; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("flush_no_done", 64'(n_done), 64'd0);
    check("flush_hi", {32'd0, hi}, {32'd0, m_hi});
    check("flush_lo", {32'd0, lo}, {32'd0, m_lo});
    run_md(DIVU_CONTROL, 32'h0000_0064, 32'h0000_0007, 1'b0, "after_flush");
    tick();

    // Flush and start together: nothing issues
    op = MULT_CONTROL; num1 = 32'd5; num2 = 32'd6; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("flush_start_no_done", 64'(n_done), 64'd0);
    check("flush_start_lo", {32'd0, lo}, {32'd0, m_lo});

    // Reset mid-MULTU with an ignored second start
    op = MULTU_CONTROL; num1 = 32'h0001_0000; num2 = 32'h0003_0000; start = 1'b1;
    tick();
    op = MULT_CONTROL; num1 = 32'd9; num2 = 32'd9;
    tick();
    start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
